key_event_fifo: RTL and testbench

Debounces the 6-bit scanned key code produced by the keyboard scanner (0 = no key, 1–16 = key) and records key events for the CPU-side keypad interface. It maintains a stable debounced key code and pushes one event per qualified press into a small show-ahead FIFO. The consumer drains the FIFO with a valid/ready handshake.

---
 rtl/key_event_fifo.sv | 198 +++++++++++++++++++
 tb/tb_key_event_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
// key_event_fifo
//   Debounces the scanned key code and queues key events for the CPU-side
//   keypad interface.
//
//   Parameters
//     STABLE_CYCLES : consecutive identical samples needed to accept a value (>= 2)
//     FIFO_DEPTH    : event FIFO entries (power of two, >= 2)
//
//   Ports
//     Clock, Reset_N : clock, asynchronous active-low reset
//     Keyb_Value     : raw scanned code, 0 = no key
//     Key_Down       : debounced key code, Key_Pressed = (Key_Down != 0)
//     Ev_Valid/Ev_Code/Ev_Ready : show-ahead event FIFO head, valid/ready pop
//     Ev_Count       : occupied FIFO entries
//     Overflow       : sticky drop flag, cleared by Overflow_Clr (set wins)
//
//   Optional feature: define KEY_RELEASE_EVENT_EN to also queue a release
//   event (6'h20 | old code[4:0]) when the key goes back to idle.
module key_event_fifo #(
  parameter int STABLE_CYCLES = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          Clock,
  input  logic                          Reset_N,
  input  logic [5:0]                    Keyb_Value,
  output logic [5:0]                    Key_Down,
  output logic                          Key_Pressed,
  output logic                          Ev_Valid,
  output logic [5:0]                    Ev_Code,
  input  logic                          Ev_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   Ev_Count,
  output logic                          Overflow,
  input  logic                          Overflow_Clr
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [NW-1:0] FULL_N  = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DEB_DOWN, S_HELD, S_DEB_UP} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [5:0]      key_down_q, key_down_d;
  logic            key_pressed_q, key_pressed_d;
  logic            push;
  logic [5:0]      push_code;

  logic [FIFO_DEPTH-1:0][5:0] mem_q, mem_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic [5:0]      ev_code_q, ev_code_d;
  logic            ev_valid_q, ev_valid_d;
  logic            ovf_q, ovf_d;
  logic            pop, full, push_ok, drop;

  // Saturating increment; reaching CNT_MAX always causes a transition.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // ---------------- debounce FSM ----------------
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    key_down_d    = key_down_q;
    push          = 1'b0;
    push_code     = 6'd0;
    case (state_q)
      S_IDLE: begin
        if (Keyb_Value != 6'd0) begin
          state_d = S_DEB_DOWN;
          cand_d  = Keyb_Value;
          cnt_d   = CW'(1);
        end
      end
      S_DEB_DOWN: begin
        if (Keyb_Value == 6'd0) begin
          state_d = S_IDLE;
          cand_d  = 6'd0;
          cnt_d   = '0;
        end else if (Keyb_Value == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d    = S_HELD;
            key_down_d = cand_q;
            push       = 1'b1;
            push_code  = cand_q;
            cnt_d      = '0;
          end
        end else begin
          cand_d = Keyb_Value;
          cnt_d  = CW'(1);
        end
      end
      S_HELD: begin
        if (Keyb_Value != key_down_q) begin
          state_d = S_DEB_UP;
          cand_d  = Keyb_Value;
          cnt_d   = CW'(1);
        end
      end
      S_DEB_UP: begin
        if (Keyb_Value == key_down_q) begin
          // Glitch back to the held key: no event.
          state_d = S_HELD;
          cand_d  = 6'd0;
          cnt_d   = '0;
        end else if (Keyb_Value == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            cnt_d  = '0;
            cand_d = 6'd0;
            if (cand_q == 6'd0) begin
              state_d    = S_IDLE;
              key_down_d = 6'd0;
`ifdef KEY_RELEASE_EVENT_EN
              push       = 1'b1;
              push_code  = 6'h20 | {1'b0, key_down_q[4:0]};
`endif
            end else begin
              // Direct key-to-key change: press for the new key only.
              state_d    = S_HELD;
              key_down_d = cand_q;
              push       = 1'b1;
              push_code  = cand_q;
            end
          end
        end else begin
          cand_d = Keyb_Value;
          cnt_d  = CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cand_d  = 6'd0;
        cnt_d   = '0;
      end
    endcase
    key_pressed_d = (key_down_d != 6'd0);
  end

  // ---------------- event FIFO ----------------
  always_comb begin
    pop     = (count_q != '0) && Ev_Ready;
    full    = (count_q == FULL_N);
    push_ok = push && (!full || pop);   // full + pop frees a slot this edge
    drop    = push && full && !pop;
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_code;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + NW'(push_ok) - NW'(pop);
    // Head register tracks the post-edge head so pops show no bubble and a
    // push into an empty FIFO is visible on the same edge.
    ev_code_d  = (count_d != '0) ? mem_d[rd_ptr_d] : ev_code_q;
    ev_valid_d = (count_d != '0);
    ovf_d      = drop ? 1'b1 : (Overflow_Clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q       <= S_IDLE;
      cand_q        <= 6'd0;
      cnt_q         <= '0;
      key_down_q    <= 6'd0;
      key_pressed_q <= 1'b0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ev_code_q     <= 6'd0;
      ev_valid_q    <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_down_q    <= key_down_d;
      key_pressed_q <= key_pressed_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ev_code_q     <= ev_code_d;
      ev_valid_q    <= ev_valid_d;
      ovf_q         <= ovf_d;
    end
  end

  assign Key_Down    = key_down_q;
  assign Key_Pressed = key_pressed_q;
  assign Ev_Valid    = ev_valid_q;
  assign Ev_Code     = ev_code_q;
  assign Ev_Count    = count_q;
  assign Overflow    = ovf_q;
endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: directed steps plus randomized key runs, checked
// against a reference that says "Key_Down becomes v once the last
// STABLE_CYCLES samples all equal v" and a queue for the event FIFO.
module tb_key_event_fifo;
  localparam int SC = 16;
  localparam int DEPTH = 4;

  logic                       Clock = 1'b0;
  logic                       Reset_N = 1'b0;
  logic [5:0]                 Keyb_Value = 6'd0;
  logic [5:0]                 Key_Down;
  logic                       Key_Pressed;
  logic                       Ev_Valid;
  logic [5:0]                 Ev_Code;
  logic                       Ev_Ready = 1'b0;
  logic [$clog2(DEPTH):0]     Ev_Count;
  logic                       Overflow;
  logic                       Overflow_Clr = 1'b0;

  key_event_fifo #(.STABLE_CYCLES(SC), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset_N(Reset_N), .Keyb_Value(Keyb_Value),
    .Key_Down(Key_Down), .Key_Pressed(Key_Pressed), .Ev_Valid(Ev_Valid),
    .Ev_Code(Ev_Code), .Ev_Ready(Ev_Ready), .Ev_Count(Ev_Count),
    .Overflow(Overflow), .Overflow_Clr(Overflow_Clr)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int         m_run;
  logic [5:0] m_last;
  logic [5:0] m_kd;
  logic [5:0] m_q[$];
  logic       m_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_last = 6'd0; m_kd = 6'd0; m_q.delete(); m_ov = 1'b0;
  endtask

  task automatic check_all();
    chk("key_down", 32'(Key_Down), 32'(m_kd));
    chk("key_pressed", 32'(Key_Pressed), 32'(m_kd != 6'd0));
    chk("ev_valid", 32'(Ev_Valid), 32'(m_q.size() != 0));
    chk("ev_count", 32'(Ev_Count), 32'(m_q.size()));
    chk("overflow", 32'(Overflow), 32'(m_ov));
    if (m_q.size() != 0) chk("ev_code", 32'(Ev_Code), 32'(m_q[0]));
  endtask

  // One clock: drive inputs, let the edge happen, advance the reference, check.
  task automatic step(input logic [5:0] kv, input logic rdy, input logic clr);
    logic       pop, has, drop;
    logic [5:0] ev;
    Keyb_Value = kv; Ev_Ready = rdy; Overflow_Clr = clr;
    pop = (m_q.size() != 0) && rdy;
    @(posedge Clock);
    has = 1'b0; drop = 1'b0; ev = 6'd0;
    if (pop) void'(m_q.pop_front());
    if (m_run != 0 && kv == m_last) begin
      if (m_run < SC) m_run++;
    end else m_run = 1;
    m_last = kv;
    if (m_run >= SC && kv != m_kd) begin
      if (kv != 6'd0) begin
        ev = kv; has = 1'b1;
      end else begin
`ifdef KEY_RELEASE_EVENT_EN
        ev = 6'h20 | {1'b0, m_kd[4:0]}; has = 1'b1;
`endif
      end
      m_kd = kv;
    end
    if (has) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else drop = 1'b1;
    end
    m_ov = drop ? 1'b1 : (clr ? 1'b0 : m_ov);
    #1;
    check_all();
  endtask

  task automatic run(input logic [5:0] kv, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(kv, rdy, 1'b0);
  endtask

  task automatic chk_reset_zero();
    chk("rst_key_down", 32'(Key_Down), 32'd0);
    chk("rst_key_pressed", 32'(Key_Pressed), 32'd0);
    chk("rst_ev_valid", 32'(Ev_Valid), 32'd0);
    chk("rst_ev_code", 32'(Ev_Code), 32'd0);
    chk("rst_ev_count", 32'(Ev_Count), 32'd0);
    chk("rst_overflow", 32'(Overflow), 32'd0);
  endtask

  initial begin
    logic [5:0] v;
    int         len;
    model_reset();
    // reset state
    #2;
    chk_reset_zero();
    @(posedge Clock); #1;
    Reset_N = 1'b1;

    // 15 samples then release: nothing accepted
    run(6'd5, SC - 1, 1'b0);
    run(6'd0, 3, 1'b0);
    chk("short_press_no_event", 32'(Ev_Valid), 32'd0);
    chk("short_press_no_key", 32'(Key_Down), 32'd0);

    // full-length press: visible after edge 16
    run(6'd5, SC - 1, 1'b0);
    chk("press_edge15", 32'(Key_Down), 32'd0);
    run(6'd5, 1, 1'b0);
    chk("press_key_down", 32'(Key_Down), 32'd5);
    chk("press_ev_code", 32'(Ev_Code), 32'd5);

    // release, then drain
    run(6'd0, SC, 1'b0);
    chk("release_key_down", 32'(Key_Down), 32'd0);
    run(6'd0, 3, 1'b1);

    // bounce: single-cycle 0 restarts the count
    run(6'd5, 8, 1'b0);
    run(6'd0, 1, 1'b0);
    run(6'd5, SC - 1, 1'b0);
    chk("bounce_no_event_yet", 32'(Ev_Valid), 32'd0);
    run(6'd5, 1, 1'b0);
    chk("bounce_one_event", 32'(Ev_Count), 32'd1);

    // glitch during hold, then direct change 5 -> 9, then release
    run(6'd7, 3, 1'b0);
    run(6'd5, 4, 1'b0);
    run(6'd9, SC, 1'b0);
    chk("change_key_down", 32'(Key_Down), 32'd9);
    run(6'd0, SC, 1'b0);
    run(6'd0, 4, 1'b1);

    // overflow: five presses via direct key changes, no pops
    run(6'd1, SC, 1'b0);
    run(6'd2, SC, 1'b0);
    run(6'd3, SC, 1'b0);
    run(6'd4, SC, 1'b0);
    run(6'd6, SC, 1'b0);
    chk("ovf_count", 32'(Ev_Count), 32'd4);
    chk("ovf_flag", 32'(Overflow), 32'd1);
    chk("ovf_head", 32'(Ev_Code), 32'd1);
    run(6'd6, 5, 1'b1);
    step(6'd6, 1'b0, 1'b1);
    chk("ovf_clear", 32'(Overflow), 32'd0);

    // full FIFO with push and pop on the same edge
    run(6'd1, SC, 1'b0);
    run(6'd2, SC, 1'b0);
    run(6'd3, SC, 1'b0);
    run(6'd4, SC, 1'b0);
    run(6'd7, SC - 1, 1'b0);
    run(6'd7, 1, 1'b1);
    chk("pushpop_count", 32'(Ev_Count), 32'd4);
    chk("pushpop_ovf", 32'(Overflow), 32'd0);
    chk("pushpop_head", 32'(Ev_Code), 32'd2);
    run(6'd7, 5, 1'b1);

    // reset mid-debounce with events queued
    run(6'd0, SC, 1'b0);
    run(6'd0, 3, 1'b1);
    run(6'd1, SC, 1'b0);
    run(6'd2, SC, 1'b0);
    run(6'd3, 10, 1'b0);
    Reset_N = 1'b0;
    #1;
    chk_reset_zero();
    model_reset();
    @(posedge Clock); @(posedge Clock); #1;
    Reset_N = 1'b1;
    run(6'd3, SC - 1, 1'b0);
    chk("rerun_not_yet", 32'(Ev_Valid), 32'd0);
    run(6'd3, 1, 1'b0);
    chk("rerun_event", 32'(Ev_Code), 32'd3);
    run(6'd3, 3, 1'b1);

    // randomized runs of key codes with random ready/clear
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 3) == 0) v = 6'd0;
      else if ($urandom_range(0, 9) == 0) v = 6'h3F;
      else v = 6'($urandom_range(1, 16));
      len = (s % 3 == 0) ? int'($urandom_range(SC, SC + 8)) : int'($urandom_range(1, SC + 4));
      for (int i = 0; i < len; i++)
        step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
